// File: rtl/v65_ctrl.sv
// ============================================================================
// v65_ctrl -- program sequencer for the 4-bit accumulator ALU
//
// Holds a 2**ADDR_W x 8-bit program store that is loaded while the block is
// not running. A run pulse starts execution at address 0. From then on it
// issues one instruction per clock as an ALU opcode/operand pair (k/d). The
// ALU's registered flags are read back for conditional jumps. A loop counter
// supports counted loops.
//
// Optional feature (macro V65_CTRL_STEP_EN):
//   When defined, a `step` input gates execution in RUN. An instruction
//   executes only in cycles with step=1. With step=0 the outputs are NOP and
//   pc, lc and state hold.
//   When undefined, there is no step port and RUN executes every cycle.
//
// Ports:
//   c          in   clock, all state updates on posedge
//   r          in   asynchronous active-high reset
//   run        in   start request (honoured in IDLE and HALT)
//   step       in   execute enable (only with V65_CTRL_STEP_EN)
//   we/wa/wd   in   program store write port (ignored in RUN)
//   cf/zf/nf   in   registered ALU flags
//   k          out  ALU opcode: 00 add, 01 or, 10 and, 11 xor
//   d          out  ALU operand
//   pc         out  current program counter
//   busy       out  high in RUN
//   done       out  high in HALT
//   dbg_state  out  FSM state (00 IDLE, 01 RUN, 10 HALT)
//   dbg_lc     out  loop counter
//
// Handshake: there is no valid/ready pair. run is a level sampled on posedge
// in IDLE/HALT. we is a level that writes on every posedge while not in RUN.
// k/d are valid every cycle and are consumed by the ALU on every posedge.
// ============================================================================
module v65_ctrl #(
    parameter int ADDR_W = 4,
    parameter int LOOP_W = 4
) (
    input  logic              c,
    input  logic              r,
    input  logic              run,
`ifdef V65_CTRL_STEP_EN
    input  logic              step,
`endif
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [7:0]        wd,
    input  logic              cf,
    input  logic              zf,
    input  logic              nf,
    output logic [1:0]        k,
    output logic [3:0]        d,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state,
    output logic [LOOP_W-1:0] dbg_lc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    // OR with zero: holds the accumulator, ALU clears cf.
    localparam logic [1:0] NOP_K = 2'b01;
    localparam logic [3:0] NOP_D = 4'b0000;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [LOOP_W-1:0] r_lc;
    logic [7:0]        r_store [0:(1<<ADDR_W)-1];

    logic [7:0]        w_ins;
    logic              w_exec;
    logic              w_cond;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_target;

    assign w_ins    = r_store[r_pc];
    assign w_pc_inc = r_pc + ADDR_W'(1);   // wraps from the last address to 0
    assign w_target = ADDR_W'(w_ins[3:0]);

`ifdef V65_CTRL_STEP_EN
    assign w_exec = (r_state == S_RUN) && step;
`else
    assign w_exec = (r_state == S_RUN);
`endif

    // Jump condition. The flags reflect the instruction executed last cycle
    // because the ALU registered them on the edge that ended it.
    always_comb begin
        w_cond = 1'b0;
        case (w_ins[5:4])
            2'b00:   w_cond = 1'b1;
            2'b01:   w_cond = zf;
            2'b10:   w_cond = nf;
            default: w_cond = cf;
        endcase
    end

    // Combinational opcode/operand. The ALU registers these on the same edge
    // that advances pc, so execution adds no latency. Anything that is not an
    // executing ALU instruction drives NOP. This includes IDLE, HALT and
    // stalled steps, and also reset, since the state resets asynchronously.
    always_comb begin
        k = NOP_K;
        d = NOP_D;
        if (w_exec && (w_ins[7:6] == 2'b00)) begin
            k = w_ins[5:4];
            d = w_ins[3:0];
        end
    end

    always_ff @(posedge c or posedge r) begin
        if (r) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_lc    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    // lc deliberately survives a restart from HALT.
                    if (run) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                    end
                end
                S_RUN: begin
                    if (w_exec) begin
                        case (w_ins[7:6])
                            2'b00: r_pc <= w_pc_inc;
                            2'b01: r_pc <= w_cond ? w_target : w_pc_inc;
                            2'b10: begin
                                if (r_lc != '0) begin
                                    r_lc <= r_lc - LOOP_W'(1);
                                    r_pc <= w_target;
                                end else begin
                                    r_pc <= w_pc_inc;
                                end
                            end
                            default: begin
                                case (w_ins[5:4])
                                    2'b00: r_state <= S_HALT;  // pc holds
                                    2'b01: begin
                                        r_lc <= LOOP_W'(w_ins[3:0]);
                                        r_pc <= w_pc_inc;
                                    end
                                    default: r_pc <= w_pc_inc;
                                endcase
                            end
                        endcase
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The store has no reset, so its contents survive r. Writes are blocked
    // only in RUN. A write in the same IDLE cycle as run lands before the
    // first fetch.
    always_ff @(posedge c) begin
        if (we && (r_state != S_RUN)) begin
            r_store[wa] <= wd;
        end
    end

    assign pc        = r_pc;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_HALT);
    assign dbg_state = r_state;
    assign dbg_lc    = r_lc;

endmodule

// File: tb/tb_v65_ctrl.sv
module tb_v65_ctrl;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic       run = 1'b0;
  logic       we = 1'b0;
  logic [3:0] wa = '0;
  logic [7:0] wd = '0;
  logic       cf, zf, nf;
  logic [1:0] k;
  logic [3:0] d;
  logic [3:0] pc;
  logic       busy, done;
  logic [1:0] dbg_state;
  logic [3:0] dbg_lc;
`ifdef V65_CTRL_STEP_EN
  logic       step = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset block ----------------
  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  v65_ctrl dut (
    .c(c), .r(r), .run(run),
`ifdef V65_CTRL_STEP_EN
    .step(step),
`endif
    .we(we), .wa(wa), .wd(wd),
    .cf(cf), .zf(zf), .nf(nf),
    .k(k), .d(d), .pc(pc), .busy(busy), .done(done),
    .dbg_state(dbg_state), .dbg_lc(dbg_lc)
  );

  // ---------------- downstream 4-bit accumulator ALU ----------------
  logic [3:0] acc;
  logic [4:0] alu_nxt;

  always_comb begin
    alu_nxt = 5'd0;
    case (k)
      2'b00:   alu_nxt = {1'b0, acc} + {1'b0, d};
      2'b01:   alu_nxt = {1'b0, acc | d};
      2'b10:   alu_nxt = {1'b0, acc & d};
      default: alu_nxt = {1'b0, acc ^ d};
    endcase
  end

  always_ff @(posedge c or posedge r) begin
    if (r) begin
      acc <= 4'd0;
      cf  <= 1'b0;
      zf  <= 1'b0;
      nf  <= 1'b0;
    end else begin
      acc <= alu_nxt[3:0];
      cf  <= alu_nxt[4];
      zf  <= (alu_nxt[3:0] == 4'd0);
      nf  <= alu_nxt[3];
    end
  end

  // ---------------- scoreboard / check ----------------
  logic [7:0] exp_q[$];   // expected {k,d,pc} per executed step

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    tick();
    r = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] v);
    we = 1'b1;
    wa = a;
    wd = v;
    tick();
    we = 1'b0;
  endtask

  task automatic start();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // Wait for done with a cycle budget. An expired budget counts as a miscompare.
  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic load_prog1();
    load(4'd0, 8'h20);
    load(4'd1, 8'h05);
    load(4'd2, 8'h03);
    load(4'd3, 8'hC0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int adds;
    logic [3:0] pc_path [6];
    logic [7:0] e;

    do_reset();

    // Reset state
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_k",     {30'd0, k},    32'd1);
    chk("rst_d",     {28'd0, d},    32'd0);
    chk("rst_pc",    {28'd0, pc},   32'd0);
    chk("rst_lc",    {28'd0, dbg_lc}, 32'd0);

    // Test 1: and 0, add 5, add 3, halt
    load_prog1();
    exp_q.push_back({2'b10, 4'h0, 2'd0});
    exp_q.push_back({2'b00, 4'h5, 2'd1});
    exp_q.push_back({2'b00, 4'h3, 2'd2});
    start();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("p1_k",  {30'd0, k},  {30'd0, e[7:6]});
      chk("p1_d",  {28'd0, d},  {28'd0, e[5:2]});
      chk("p1_pc", {28'd0, pc}, {30'd0, e[1:0]});
      tick();
    end
    chk("p1_halt_pc",   {28'd0, pc}, 32'd3);
    chk("p1_halt_k",    {30'd0, k},  32'd1);
    chk("p1_halt_busy", {31'd0, busy}, 32'd1);
    tick();   // fourth edge after run
    chk("p1_done", {31'd0, done}, 32'd1);
    chk("p1_pc",   {28'd0, pc},   32'd3);
    chk("p1_acc",  {28'd0, acc},  32'd8);

    // Test 2: conditional jump on carry (loaded while in HALT)
    load(4'd0, 8'h20);
    load(4'd1, 8'h0F);
    load(4'd2, 8'h01);
    load(4'd3, 8'h75);
    load(4'd4, 8'hC0);
    load(4'd5, 8'h3F);
    load(4'd6, 8'hC0);
    pc_path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6};
    start();
    for (int i = 0; i < 6; i++) begin
      chk("p2_pc", {28'd0, pc}, {28'd0, pc_path[i]});
      tick();
    end
    chk("p2_done", {31'd0, done}, 32'd1);
    chk("p2_pc_halt", {28'd0, pc}, 32'd6);
    chk("p2_acc", {28'd0, acc}, 32'd15);

    // Test 3: counted loop, ldc 2 -> body three times
    load(4'd0, 8'h20);
    load(4'd1, 8'hD2);
    load(4'd2, 8'h01);
    load(4'd3, 8'h82);
    load(4'd4, 8'hC0);
    start();
    adds = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy && k == 2'b00 && d == 4'd1) begin
        if (adds == 0) chk("p3_lc_loaded", {28'd0, dbg_lc}, 32'd2);
        adds++;
      end
      tick();
    end
    chk("p3_done", {31'd0, done}, 32'd1);
    chk("p3_adds", adds, 32'd3);
    chk("p3_acc",  {28'd0, acc},    32'd3);
    chk("p3_lc",   {28'd0, dbg_lc}, 32'd0);
    chk("p3_pc",   {28'd0, pc},     32'd4);

    // Test 4: async reset mid-RUN at pc=2, then rerun from intact store
    load_prog1();
    start();
    tick();
    tick();
    chk("p4_pre_pc", {28'd0, pc}, 32'd2);
    r = 1'b1;
    #1;   // no clock edge in between
    chk("p4_busy", {31'd0, busy}, 32'd0);
    chk("p4_pc",   {28'd0, pc},   32'd0);
    chk("p4_k",    {30'd0, k},    32'd1);
    chk("p4_d",    {28'd0, d},    32'd0);
    tick();
    r = 1'b0;
    start();
    wait_done(10);
    chk("p4_rerun_pc",  {28'd0, pc},  32'd3);
    chk("p4_rerun_acc", {28'd0, acc}, 32'd8);

    // Write in the same IDLE cycle as run: first fetch sees the new word
    do_reset();
    we = 1'b1; wa = 4'd0; wd = 8'hC0; run = 1'b1;
    tick();
    we = 1'b0; run = 1'b0;
    chk("wr_run_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("wr_run_done", {31'd0, done}, 32'd1);
    chk("wr_run_pc",   {28'd0, pc},   32'd0);

    // Test 5: 16 x add 0, pc wraps, writes during RUN are ignored
    for (int i = 0; i < 16; i++) load(4'(i), 8'h00);
    start();
    for (int i = 0; i < 34; i++) begin
      chk("p5_pc",   {28'd0, pc},   i % 16);
      chk("p5_busy", {31'd0, busy}, 32'd1);
      // A leaked write of HALT would stop the run within a lap.
      we = (i % 3 == 0);
      wa = 4'((i + 5) % 16);
      wd = 8'hC0;
      tick();
    end
    we = 1'b0;

`ifdef V65_CTRL_STEP_EN
    // Test 6: step every third cycle on program 1
    do_reset();
    load_prog1();
    exp_q.push_back({2'b10, 4'h0, 2'd0});
    exp_q.push_back({2'b00, 4'h5, 2'd1});
    exp_q.push_back({2'b00, 4'h3, 2'd2});
    start();
    for (int i = 0; i < 40 && !done; i++) begin
      step = (i % 3 == 2);
      #1;
      if (!step) begin
        chk("p6_stall_k", {30'd0, k}, 32'd1);
        chk("p6_stall_d", {28'd0, d}, 32'd0);
      end else if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("p6_k",  {30'd0, k},  {30'd0, e[7:6]});
        chk("p6_d",  {28'd0, d},  {28'd0, e[5:2]});
        chk("p6_pc", {28'd0, pc}, {30'd0, e[1:0]});
      end
      tick();
    end
    step = 1'b0;
    chk("p6_done", {31'd0, done}, 32'd1);
    chk("p6_left", exp_q.size(), 32'd0);
    chk("p6_acc",  {28'd0, acc}, 32'd8);
`endif

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
